imem_fetch_arbiter: RTL and testbench

Sequencing controller and two-port round-robin arbiter for the 8-word × 32-bit instruction memory. It accepts read requests from two requesters: port 0, the fetch unit, and port 1, the debug/loader path. It drives the memory's address input and returns the registered instruction word to the winning requester over a valid/ready response channel. The block sits directly in front of the instruction memory and is the only block that drives its address.

---
 rtl/imem_arb_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 35 +++
 rtl/imem_fetch_arbiter.sv | 94 +++++++++
 tb/tb_imem_fetch_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
// Imported by the arbiter top level and its round-robin sub-module.
package imem_arb_pkg;

   localparam int          NUM_REQ = 2;
   localparam logic [31:0] NOP     = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter. The port that was not granted last wins a tie.
// last_gnt resets to port 1, so the first tie goes to port 0.
module rr_arbiter_2
   import imem_arb_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt
);

   logic last_gnt;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_gnt <= 1'b1;
      end else if (advance && (|gnt)) begin
         last_gnt <= gnt[1];
      end
   end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Sequencing controller in front of the instruction memory: arbitrates fetch and
// debug/loader reads, drives mem_addr and returns the registered word per port.
module imem_fetch_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ADDR_W-1:0]  req_addr0,
   input  logic [ADDR_W-1:0]  req_addr1,
   output logic [NUM_REQ-1:0] req_ready,
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_instr,
   output logic               busy
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                gnt_q;
   logic [DATA_W-1:0]   data_q;
   logic [NUM_REQ-1:0]  arb_req;
   logic [NUM_REQ-1:0]  gnt;
   logic                in_idle;

   // Requests are only visible to the arbiter in IDLE, so READ/RESP never accept.
   assign in_idle = (state_q == IDLE);
   assign arb_req = in_idle ? req_valid : '0;

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (in_idle),
      .gnt     (gnt)
   );

   assign req_ready = gnt;
   assign mem_addr  = addr_q;
   assign busy      = !in_idle;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rsp_valid = '0;
      rsp_data  = DATA_W'(NOP);
      case (state_q)
         IDLE: begin
            if (|gnt) state_d = READ;
         end
         READ: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_data         = data_q;
            if (rsp_ready[gnt_q]) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: data_q is a single register, not a memory, so it is reset to keep rsp_data defined.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         gnt_q  <= 1'b0;
         data_q <= DATA_W'(NOP);
      end else begin
         if (|gnt) begin
            addr_q <= gnt[1] ? req_addr1 : req_addr0;
            gnt_q  <= gnt[1];
         end
         if (state_q == READ) begin
            data_q <= mem_instr;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a transaction-level reference model of the arbiter.
module tb_imem_fetch_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [2:0]  req_addr0, req_addr1;
   logic [1:0]  req_ready, rsp_valid, rsp_ready;
   logic [31:0] rsp_data, mem_instr;
   logic [2:0]  mem_addr;
   logic        busy;

   logic [31:0] mem [8];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: one outstanding transaction, aged in cycles since acceptance
   bit m_pend;
   int m_port, m_addr, m_age, m_last, m_mem_addr, m_acc;

   logic [1:0]  obs_ready, obs_valid;
   logic [31:0] obs_data;
   logic [2:0]  obs_addr;
   logic        obs_busy;

   always #5 clk = ~clk;

   initial for (int i = 0; i < 8; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
   assign mem_instr = mem[mem_addr];

   imem_fetch_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr0 (req_addr0),
      .req_addr1 (req_addr1),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mem_addr  (mem_addr),
      .mem_instr (mem_instr),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend     = 1'b0;
      m_port     = 0;
      m_addr     = 0;
      m_age      = 0;
      m_last     = 1;
      m_mem_addr = 0;
      m_acc      = -1;
   endtask

   // Samples at negedge, compares with the model, then advances the model to the next edge.
   task automatic cycle();
      logic [1:0] e_ready, e_valid;
      int w;
      @(negedge clk);
      obs_ready = req_ready;
      obs_valid = rsp_valid;
      obs_data  = rsp_data;
      obs_addr  = mem_addr;
      obs_busy  = busy;
      e_ready = 2'b00;
      e_valid = 2'b00;
      w = -1;
      if (!m_pend) begin
         if (req_valid == 2'b11) w = 1 - m_last;
         else if (req_valid[0])  w = 0;
         else if (req_valid[1])  w = 1;
         if (w >= 0) e_ready[w] = 1'b1;
      end else if (m_age >= 2) begin
         e_valid[m_port] = 1'b1;
      end
      check("req_ready", 32'(obs_ready), 32'(e_ready));
      check("rsp_valid", 32'(obs_valid), 32'(e_valid));
      check("busy", 32'(obs_busy), 32'(m_pend));
      check("mem_addr", 32'(obs_addr), 32'(m_mem_addr));
      if (e_valid != 2'b00) check("rsp_data", obs_data, 32'hC0DE_0000 + 32'(m_addr));
      m_acc = -1;
      if (w >= 0) begin
         m_pend     = 1'b1;
         m_port     = w;
         m_addr     = (w == 1) ? int'(req_addr1) : int'(req_addr0);
         m_age      = 1;
         m_last     = w;
         m_mem_addr = m_addr;
         m_acc      = w;
      end else if (m_pend) begin
         if (m_age >= 2 && rsp_ready[m_port]) m_pend = 1'b0;
         else m_age++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_data"}, rsp_data, 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_reset_outputs("rst");
      reset = 1'b1;
   endtask

   task automatic drain(input int n);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (n) cycle();
   endtask

   initial begin
      int gport[$];
      int gcyc[$];
      logic [31:0] rdat[$];
      int g0;
      bit want[2];

      req_addr0 = '0;
      req_addr1 = '0;
      do_reset();

      // single fetch latency
      req_valid = 2'b01; req_addr0 = 3'd3; rsp_ready = 2'b11;
      cycle(); check("t1_ready", 32'(obs_ready), 32'd1);
      req_valid = 2'b00;
      cycle(); check("t1_mem_addr", 32'(obs_addr), 32'd3);
      cycle(); check("t1_valid", 32'(obs_valid), 32'd1);
      check("t1_data", obs_data, 32'hC0DE_0003);
      cycle(); check("t1_idle", 32'(obs_busy), 32'd0);

      // continuous contention alternates grants
      do_reset();
      req_valid = 2'b11; req_addr0 = 3'd1; req_addr1 = 3'd6; rsp_ready = 2'b11;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (obs_ready != 2'b00) begin
            gport.push_back(obs_ready[1] ? 1 : 0);
            gcyc.push_back(c);
         end
         if (obs_valid != 2'b00) rdat.push_back(obs_data);
      end
      req_valid = 2'b00;
      check("t2_ngrant", 32'(gport.size()), 32'd4);
      check("t2_nresp", 32'(rdat.size()), 32'd4);
      for (int k = 0; k < gport.size() && k < 4; k++) begin
         check("t2_gport", 32'(gport[k]), 32'(k % 2));
         if (k > 0) check("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      end
      for (int k = 0; k < rdat.size() && k < 4; k++)
         check("t2_rdata", rdat[k], (k % 2 == 0) ? 32'hC0DE_0001 : 32'hC0DE_0006);
      drain(3);

      // stalled response on port 1, foreign rsp_ready ignored, port 0 waits
      req_valid = 2'b10; req_addr1 = 3'd7; rsp_ready = 2'b00;
      cycle(); check("t3_ready1", 32'(obs_ready), 32'd2);
      req_valid = 2'b01; req_addr0 = 3'd2;
      cycle();
      rsp_ready = 2'b01;
      for (int s = 0; s < 5; s++) begin
         cycle();
         check("t3_stall_valid", 32'(obs_valid), 32'd2);
         check("t3_stall_data", obs_data, 32'hC0DE_0007);
         check("t3_stall_ready", 32'(obs_ready), 32'd0);
         check("t3_stall_busy", 32'(obs_busy), 32'd1);
      end
      rsp_ready = 2'b10;
      cycle(); check("t3_hs_ready", 32'(obs_ready), 32'd0);
      rsp_ready = 2'b11;
      cycle(); check("t3_after_ready", 32'(obs_ready), 32'd1);
      drain(3);

      // asynchronous reset while in READ
      req_valid = 2'b01; req_addr0 = 3'd5; rsp_ready = 2'b11;
      cycle();
      req_valid = 2'b00;
      #2 reset = 1'b0;
      #1 check_reset_outputs("t5_async");
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      rsp_ready = 2'b11;
      for (int s = 0; s < 3; s++) begin
         cycle();
         check("t5_no_rsp", 32'(obs_valid), 32'd0);
      end
      req_valid = 2'b11; req_addr0 = 3'd2; req_addr1 = 3'd4;
      cycle(); check("t5_first_tie", 32'(obs_ready), 32'd1);
      drain(4);

      // lone requester is never held off by round-robin state
      req_valid = 2'b01; req_addr0 = 3'd0; rsp_ready = 2'b11;
      g0 = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (obs_ready == 2'b01) g0++;
      end
      check("t6_grants", 32'(g0), 32'd4);
      drain(4);

      // randomized traffic; requesters hold valid and address until accepted
      want[0] = 1'b0;
      want[1] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!want[p] && $urandom_range(0, 2) == 0) begin
               want[p] = 1'b1;
               if (p == 0) req_addr0 = 3'($urandom_range(0, 7));
               else        req_addr1 = 3'($urandom_range(0, 7));
            end
         end
         req_valid = {want[1], want[0]};
         rsp_ready = 2'($urandom_range(0, 3));
         cycle();
         if (m_acc >= 0) want[m_acc] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
